// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StFlush  = 2'd2,
        StHalted = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC: exception vector, jump, branch, PC+4, hold.
// With PC_ALIGN_CHECK_EN a misaligned redirect target becomes an exception.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [WORD_W-1:0] pc,
    input  logic              exception,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              advance,
    output logic [WORD_W-1:0] next_pc,
    output logic              redirect,
    output logic              take_exc
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misaligned
`endif
);

    logic              target_req;
    logic [WORD_W-1:0] sel_target;
    logic [WORD_W-1:0] clean_target;

    assign target_req = jump | branch_taken;
    assign sel_target = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned   = target_req & ~exception & (sel_target[1:0] != 2'b00);
    assign take_exc     = exception | misaligned;
    assign clean_target = sel_target;
`else
    assign take_exc     = exception;
    assign clean_target = sel_target & ~32'h0000_0003;
`endif

    assign redirect = exception | target_req;

    always_comb begin
        next_pc = pc;
        if (take_exc) begin
            next_pc = EXC_VECTOR;
        end else if (target_req) begin
            next_pc = clean_target;
        end else if (advance) begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner and IF-stage fetch sequencer (BOOT/RUN/FLUSH/HALTED).
// Optional macro PC_ALIGN_CHECK_EN traps misaligned redirect targets.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [WORD_W-1:0] Branch_Target,
    input  logic              Jump,
    input  logic [WORD_W-1:0] Jump_Target,
    input  logic              Exception,
    input  logic              Halt,
    input  logic              Fetch_Ready,
    output logic [WORD_W-1:0] PC_Out,
    output logic [WORD_W-1:0] PC_Plus4,
    output logic              Fetch_Valid,
    output logic              Flush,
    output logic [WORD_W-1:0] EPC,
    output logic [1:0]        State
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              Misaligned
`endif
);

    pc_state_e         state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] epc_q;
    logic              fetch_valid_q;
    logic              flush_q;

    logic              live;
    logic              exc_in;
    logic              jump_in;
    logic              branch_in;
    logic              advance;
    logic [WORD_W-1:0] next_pc;
    logic              redirect;
    logic              take_exc;

    // Redirects only matter once fetching; HALTED listens to exceptions alone.
    assign live      = (state_q == StRun) || (state_q == StFlush);
    assign exc_in    = Exception & (state_q != StBoot);
    assign jump_in   = Jump & live;
    assign branch_in = Branch_Taken & live;
    assign advance   = (state_q == StRun) & fetch_valid_q & Fetch_Ready & ~Stall & ~Halt;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic misaligned_q;
`endif

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .pc            (pc_q),
        .exception     (exc_in),
        .jump          (jump_in),
        .jump_target   (Jump_Target),
        .branch_taken  (branch_in),
        .branch_target (Branch_Target),
        .advance       (advance),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .take_exc      (take_exc)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            pc_q <= next_pc;
            if (take_exc) begin
                epc_q <= pc_q;
            end
`ifdef PC_ALIGN_CHECK_EN
            misaligned_q <= misaligned;
`endif
            case (state_q)
                StBoot: begin
                    state_q       <= StRun;
                    fetch_valid_q <= 1'b1;
                    flush_q       <= 1'b0;
                end
                StRun, StFlush: begin
                    if (redirect) begin
                        state_q       <= StFlush;
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b1;
                    end else if (Halt) begin
                        state_q       <= StHalted;
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b0;
                    end else begin
                        state_q       <= StRun;
                        fetch_valid_q <= 1'b1;
                        flush_q       <= 1'b0;
                    end
                end
                StHalted: begin
                    if (redirect) begin
                        state_q       <= StFlush;
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= StBoot;
                    fetch_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                end
            endcase
        end
    end

    assign PC_Out      = pc_q;
    assign PC_Plus4    = pc_q + 32'd4;
    assign Fetch_Valid = fetch_valid_q;
    assign Flush       = flush_q;
    assign EPC         = epc_q;
    assign State       = state_q;
`ifdef PC_ALIGN_CHECK_EN
    assign Misaligned  = misaligned_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural program counter and sequences instruction fetch for the MIPS core.
- Each cycle selects next PC by priority: exception vector, jump target, branch target, then PC+4.
- Handles stalls, instruction-memory back-pressure, halt, and one-cycle fetch flush after every redirect.
- Sits between IF-stage instruction memory and the ID/EX hazard/branch logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, exception handler entry address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit holds PC.
- Branch_Taken  in  1  resolved taken branch.
- Branch_Target  in  32  branch destination.
- Jump  in  1  jump (J/JAL/JR) resolved.
- Jump_Target  in  32  jump destination.
- Exception  in  1  exception raised this cycle.
- Halt  in  1  stop fetching.
- Fetch_Ready  in  1  instruction memory accepts request.
- PC_Out  out  32  current fetch address.
- PC_Plus4  out  32  PC_Out + 4, combinational; feeds link register.
- Fetch_Valid  out  1  fetch request valid.
- Flush  out  1  kill IF/ID contents.
- EPC  out  32  PC of faulting fetch.
- State  out  2  FSM state, for debug.

Behaviour:
- Reset when rst=1 at an edge: PC_Out=RESET_PC, EPC=0, Fetch_Valid=0, Flush=0, State=BOOT. rst overrides every other input.
- States and encodings: BOOT=0, RUN=1, FLUSH=2, HALTED=3.
- BOOT: Fetch_Valid=0. Unconditionally goes to RUN next cycle.
- RUN: Fetch_Valid=1.
  - Accept = Fetch_Valid & Fetch_Ready.
  - Redirect priority: Exception > Jump > Branch_Taken.
  - On any redirect: the redirect applies regardless of Stall and Fetch_Ready. PC loads the selected target. Flush=1 for exactly the next cycle. State goes to FLUSH.
  - On Exception: EPC <= PC_Out and PC <= EXC_VECTOR.
  - No redirect, Halt=1: go to HALTED with PC held.
  - No redirect, Halt=0, Accept=1, Stall=0: PC <= PC+4.
  - Otherwise: PC held. Fetch_Valid stays 1 and PC_Out stays stable while Fetch_Ready=0.
- FLUSH: Fetch_Valid=0, Flush=1. Returns to RUN next cycle.
  - A new redirect in FLUSH loads its target and stays in FLUSH.
  - Halt in FLUSH goes to HALTED.
- HALTED: Fetch_Valid=0, PC held.
  - Only Exception (goes to FLUSH with PC=EXC_VECTOR) or rst leaves this state.
  - Jump, Branch_Taken and Stall are ignored.
- Arithmetic: 32-bit unsigned, carry discarded; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Latency:
  - Redirect input to new PC_Out: 1 cycle.
  - New PC to first valid fetch: 2 cycles, because of the FLUSH bubble.
- Simultaneous Exception and Halt: Exception wins.
- Simultaneous Jump and Branch_Taken: Jump wins.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect target with bits [1:0] != 0 is treated as an Exception: EPC <= PC_Out, PC <= EXC_VECTOR.
  - Adds output port Misaligned (1 bit), which pulses 1 for one cycle.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - No Misaligned port.

Decomposition:
- Shared package: state encodings (BOOT, RUN, FLUSH, HALTED), default RESET_PC and EXC_VECTOR constants, and a 32-bit word width constant.
- One natural sub-module, pc_next_mux: combinational priority select of the next PC plus the redirect flag. The FSM and registers stay in pc_sequencer.

Test Plan:
- rst=1 for 2 cycles, then release with Fetch_Ready=1 -> PC_Out=0 and BOOT for 1 cycle, then RUN; PC_Out runs 0, 4, 8, 12 with Fetch_Valid=1.
- At PC=0x10, Stall=1 for 3 cycles, then Fetch_Ready=0 for 2 cycles -> PC_Out holds 0x10 throughout; resumes at 0x14.
- Jump=1 and Branch_Taken=1 together, Jump_Target=0x400, Branch_Target=0x200 -> PC_Out=0x400; Flush=1 and Fetch_Valid=0 for one cycle; next fetch is 0x400.
- At PC=0x20, Exception=1 together with Halt=1 and Stall=1 -> EPC=0x20, PC_Out=0x80, FLUSH then RUN.
- Halt=1 at PC=0x30, then Jump=1 -> HALTED, PC stays 0x30; later Exception=1 -> PC=0x80.
- PC=0xFFFF_FFFC accepted -> next PC=0x0000_0000.
- With PC_ALIGN_CHECK_EN, Branch_Target=0x102 -> Misaligned=1 and PC=0x80. Without it -> PC=0x100.
